// File: rtl/fpro_timer_core.sv
// FPro MMIO slot timer: 64-bit up-counter with prescaler, periodic auto-reload and sticky expiry flag.
// Define TIMER_IRQ_EN to implement CTRL.IRQ_EN and drive irq; otherwise irq is tied low.
module fpro_timer_core #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  typedef enum logic [4:0] {
    REG_CTRL     = 5'd0,
    REG_COUNT_LO = 5'd1,
    REG_COUNT_HI = 5'd2,
    REG_PERIOD   = 5'd3,
    REG_STATUS   = 5'd4,
    REG_PRESCALE = 5'd5
  } reg_addr_e;

  logic                  wr_en, rd_en, clr, tick, reload, expire;
  logic                  go_q, go_d, mode_q, mode_d, exp_q, exp_d, irq_en;
  logic [63:0]           count_q, count_d;
  logic [31:0]           period_q, period_d, hi_q, hi_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d, prescale_q, prescale_d;

  assign wr_en  = cs & write;
  assign rd_en  = cs & read;
  assign clr    = wr_en && (addr == REG_CTRL) && wr_data[1];
  assign tick   = go_q && (pre_cnt_q == prescale_q);
  // >= rather than == so a PERIOD lowered below the running count reloads on the next tick
  assign reload = mode_q && (count_q[63:32] == 32'd0) && (count_q[31:0] >= period_q);
  assign expire = tick && (mode_q ? reload : (count_q == '1));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch
    go_d       = go_q;
    mode_d     = mode_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    hi_d       = hi_q;
    exp_d      = exp_q;

    if (go_q) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) count_d = reload ? 64'd0 : count_q + 64'd1;
    end
    // Shadow captures the pre-tick count so a LO-then-HI read pair is coherent
    if (rd_en && (addr == REG_COUNT_LO)) hi_d = count_q[63:32];
    if (clr) begin
      count_d   = 64'd0;
      pre_cnt_d = '0;
      hi_d      = 32'd0;
    end

    if (wr_en && (addr == REG_STATUS) && wr_data[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    if (wr_en) begin
      case (addr)
        REG_CTRL: begin
          go_d   = wr_data[0];
          mode_d = wr_data[2];
        end
        REG_PERIOD:   period_d   = wr_data;
        REG_PRESCALE: prescale_d = wr_data[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is asynchronous and clears every register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_q       <= 1'b0;
      mode_q     <= 1'b0;
      period_q   <= 32'd0;
      prescale_q <= '0;
      count_q    <= 64'd0;
      pre_cnt_q  <= '0;
      hi_q       <= 32'd0;
      exp_q      <= 1'b0;
    end else begin
      go_q       <= go_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      hi_q       <= hi_d;
      exp_q      <= exp_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else if (wr_en && (addr == REG_CTRL)) begin
      irq_en_q <= wr_data[3];
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = exp_q & irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_data = 32'd0;
    if (rd_en) begin
      case (addr)
        REG_CTRL:     rd_data = {28'd0, irq_en, mode_q, 1'b0, go_q};
        REG_COUNT_LO: rd_data = count_q[31:0];
        REG_COUNT_HI: rd_data = hi_q;
        REG_PERIOD:   rd_data = period_q;
        REG_STATUS:   rd_data = {31'd0, exp_q};
        REG_PRESCALE: rd_data = 32'(prescale_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_timer_core.sv
// Scoreboard bench for fpro_timer_core: driver pushes model-predicted read data, a negedge monitor pops and compares.
// Honours TIMER_IRQ_EN the same way the design does.
module tb_fpro_timer_core;

  localparam int PW = 16;
  localparam logic [63:0] PRE_MASK = (64'd1 << PW) - 64'd1;
`ifdef TIMER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        irq;

  always #5 clk = ~clk;

  fpro_timer_core #(.PRESCALE_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] poke_val;

  // Reference model: architectural state as plain numbers
  bit [63:0] m_count, m_pre, m_prescale;
  bit [31:0] m_period, m_hi;
  bit        m_go, m_mode, m_irq_en, m_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic void model_reset();
    m_count = 0; m_pre = 0; m_prescale = 0; m_period = 0; m_hi = 0;
    m_go = 0; m_mode = 0; m_irq_en = 0; m_exp = 0;
  endfunction

  function automatic logic [31:0] model_data(input logic [4:0] a);
    case (a)
      5'd0:    return {28'd0, m_irq_en, m_mode, 1'b0, m_go};
      5'd1:    return m_count[31:0];
      5'd2:    return m_hi;
      5'd3:    return m_period;
      5'd4:    return {31'd0, m_exp};
      5'd5:    return m_prescale[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_will_reload();
    return m_go && (m_pre == m_prescale) && m_mode &&
           (m_count < 64'h1_0000_0000) && (m_count[31:0] >= m_period);
  endfunction

  // Advance the model across one clock edge with the given bus activity
  function automatic void model_edge(input bit wr, input bit rd, input logic [4:0] a, input logic [31:0] d);
    bit        tick, expire;
    bit [63:0] next;
    tick   = m_go && (m_pre == m_prescale);
    expire = 0;
    next   = m_count;
    if (tick) begin
      if (model_will_reload()) begin
        next = 0;
        expire = 1;
      end else begin
        next = m_count + 64'd1;
        expire = !m_mode && (next == 0);
      end
    end
    if (m_go) m_pre = tick ? 64'd0 : ((m_pre + 64'd1) & PRE_MASK);
    if (rd && a == 5'd1) m_hi = m_count[63:32];
    m_count = next;
    if (wr && a == 5'd0 && d[1]) begin
      m_count = 0; m_pre = 0; m_hi = 0;
    end
    if (wr && a == 5'd4 && d[0]) m_exp = 0;
    if (expire) m_exp = 1;
    if (wr) begin
      case (a)
        5'd0: begin m_go = d[0]; m_mode = d[2]; m_irq_en = HAS_IRQ & d[3]; end
        5'd3: m_period = d;
        5'd5: m_prescale = {32'd0, d} & PRE_MASK;
        default: ;
      endcase
    end
  endfunction

  task automatic bus_cycle(input bit c, input bit r, input bit w, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk); #1;
    cs = c; read = r; write = w; addr = a; wr_data = d;
    if (c && r) begin
      e.addr = a;
      e.data = model_data(a);
      e.irq  = m_exp & m_irq_en;
      sb_q.push_back(e);
    end
    model_edge(c && w, c && r, a, d);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    bus_cycle(1'b1, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Load the counter directly (GO must be 0); two quiet edges let the forced value settle into the flop
  task automatic poke_count(input logic [63:0] v);
    @(posedge clk); #1;
    cs = 0; read = 0; write = 0;
    poke_val = v;
    force dut.count_q = poke_val;
    @(posedge clk); #1;
    release dut.count_q;
    m_count = v;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && cs && read) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read@%0d: got 0x%08h, expected no read", addr, rd_data);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rd_data@%0d", e.addr), rd_data, e.data);
        check($sformatf("irq@%0d", e.addr), {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state of every offset
    for (int a = 0; a < 8; a++) rd(5'(a));

    // First count with no prescale
    wr(5'd5, 32'd0);
    wr(5'd0, 32'h1);
    idle(10);
    rd(5'd1);

    // Prescaler of 3: one tick every 4 cycles
    wr(5'd0, 32'h2);
    wr(5'd5, 32'd3);
    wr(5'd0, 32'h1);
    idle(39);
    rd(5'd1);
    for (int i = 0; i < 12; i++) rd(5'd1);

    // Periodic reload with PERIOD=5, then W1C of the sticky flag
    wr(5'd0, 32'h2);
    wr(5'd4, 32'h1);
    wr(5'd3, 32'd5);
    wr(5'd5, 32'd0);
    wr(5'd0, 32'hD);
    for (int i = 0; i < 16; i++) rd((i % 3 == 2) ? 5'd4 : 5'd1);
    wr(5'd4, 32'h1);
    rd(5'd4);
    rd(5'd1);

    // W1C on the exact expiry cycle: set wins
    for (int i = 0; i < 20; i++) begin
      if (model_will_reload()) begin
        wr(5'd4, 32'h1);
        break;
      end
      idle(1);
    end
    rd(5'd4);
    rd(5'd1);

    // Coherent 64-bit read across the 32-bit carry
    wr(5'd0, 32'h2);
    wr(5'd4, 32'h1);
    poke_count(64'h0000_0000_FFFF_FFFD);
    wr(5'd0, 32'h1);
    rd(5'd1); rd(5'd1); rd(5'd1);
    rd(5'd2);
    rd(5'd1);
    rd(5'd2);

    // CLR while running keeps GO
    wr(5'd0, 32'h3);
    rd(5'd2);
    rd(5'd1);
    rd(5'd0);

    // Free-run wrap of the full 64 bits sets EXP
    wr(5'd0, 32'h2);
    wr(5'd4, 32'h1);
    poke_count(64'hFFFF_FFFF_FFFF_FFFD);
    wr(5'd0, 32'h9);
    for (int i = 0; i < 5; i++) rd(5'd4);
    rd(5'd1);
    rd(5'd2);

    // Randomised register traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned op;
      logic [4:0]  a;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      case (a)
        5'd0:    d = $urandom & 32'hF;
        5'd3:    d = $urandom_range(0, 12);
        5'd5:    d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      if (op < 6)       rd(a);
      else if (op < 8)  wr(a, d);
      else if (op == 8) bus_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, a, d);
      else              idle(1);
    end

    // Asynchronous reset mid-count
    wr(5'd0, 32'h2);
    wr(5'd3, 32'd2);
    wr(5'd5, 32'd0);
    wr(5'd0, 32'hD);
    idle(6);
    @(posedge clk); #1;
    cs = 1; read = 1; write = 0; addr = 5'd1;
    #1;
    check("lo_before_reset", rd_data, m_count[31:0]);
    check("irq_before_reset", {31'd0, irq}, {31'd0, m_exp & m_irq_en});
    #1 reset_n = 1'b0;
    #1;
    check("rd_data_async_reset", rd_data, 32'd0);
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    cs = 0; read = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 6; a++) rd(5'(a));
    idle(3);
    rd(5'd1);

    idle(2);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
